// File: rtl/mpadd_seq.sv
// Streaming multi-precision adder: word pairs arrive least-significant first, each is summed
// by a carry-select adder with the carry chained across words. Optional out_zero via MPADD_SEQ_ZERO_FLAG_EN.
module mpadd_seq #(
  parameter int BYTES = 4,
  parameter int W     = BYTES * 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic         out_last,
  output logic         out_cout,
  output logic         err
`ifdef MPADD_SEQ_ZERO_FLAG_EN
  ,
  output logic         out_zero
`endif
);

  typedef enum logic {S_FIRST, S_MID} state_t;

  state_t         state_q, state_d;
  logic           carry_q, carry_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           last_q, last_d;
  logic           cout_q, cout_d;
  logic           err_q, err_d;

  logic           accept;
  logic           eff_first;
  logic           framing_err;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  CSAdder #(.W(W)) u_add (
    .a   (in_a),
    .b   (in_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  // A word arriving while idle always starts an operation, flagged or not.
  assign eff_first = (state_q == S_FIRST) || in_first;
  assign add_cin   = eff_first ? in_cin : carry_q;
  assign framing_err = (state_q == S_FIRST) ? !in_first : in_first;

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cout_d  = cout_q;
    err_d   = 1'b0;
    valid_d = out_ready ? 1'b0 : valid_q;
    if (accept) begin
      carry_d = add_cout;
      sum_d   = add_sum;
      last_d  = in_last;
      cout_d  = in_last ? add_cout : 1'b0;
      valid_d = 1'b1;
      err_d   = framing_err;
      state_d = in_last ? S_FIRST : S_MID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FIRST;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_q     = sum_q;
  assign out_last  = last_q;
  assign out_cout  = cout_q;
  assign err       = err_q;

`ifdef MPADD_SEQ_ZERO_FLAG_EN
  logic zacc_q, zacc_d;
  logic zero_q, zero_d;
  logic zero_run;

  // Running "all words zero so far" including the current one.
  assign zero_run = (add_sum == '0) && (eff_first || zacc_q);

  always_comb begin
    zacc_d = zacc_q;
    zero_d = zero_q;
    if (accept) begin
      zacc_d = zero_run;
      zero_d = in_last && zero_run && !add_cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zacc_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      zero_q <= zero_d;
    end
  end

  assign out_zero = zero_q;
`endif

endmodule

// Carry-select adder: each byte computes both carry-in sums in parallel, the incoming
// carry picks one. W is expected to be a multiple of 8.
module CSAdder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NB = W / 8;

  logic [NB:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < NB; gi++) begin : g_blk
    logic [8:0] s0;
    logic [8:0] s1;
    assign s0 = {1'b0, a[gi*8 +: 8]} + {1'b0, b[gi*8 +: 8]};
    assign s1 = {1'b0, a[gi*8 +: 8]} + {1'b0, b[gi*8 +: 8]} + 9'd1;
    assign sum[gi*8 +: 8] = c[gi] ? s1[7:0] : s0[7:0];
    assign c[gi+1]        = c[gi] ? s1[8]   : s0[8];
  end

  assign cout = c[NB];

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq: single word, carry chaining, backpressure, framing errors,
// reset mid-operation, and the zero flag when MPADD_SEQ_ZERO_FLAG_EN is defined.
module tb_mpadd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_first;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic        out_last;
  logic        out_cout;
  logic        err;
`ifdef MPADD_SEQ_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int checks   = 0;
  int failures = 0;

  mpadd_seq #(.BYTES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_last (out_last),
    .out_cout (out_cout),
    .err      (err)
`ifdef MPADD_SEQ_ZERO_FLAG_EN
    ,
    .out_zero (out_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word pair, let one rising edge accept it, sample 1 time unit later.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic first, input logic last);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("txn a=%08h b=%08h cin=%0d first=%0d last=%0d -> q=%08h last=%0d cout=%0d err=%0d",
             a, b, cin, first, last, out_q, out_last, out_cout, err);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_first = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_q", out_q, 0);
    check("rst_last", out_last, 0);
    check("rst_cout", out_cout, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Single word with carry out and wrap to zero
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    check("single_valid", out_valid, 1);
    check("single_q", out_q, 32'h0000_0000);
    check("single_last", out_last, 1);
    check("single_cout", out_cout, 1);
    check("single_err", err, 0);

    // Two-word chain with cin=1
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    check("chain_q0", out_q, 32'h0000_0001);
    check("chain_last0", out_last, 0);
    check("chain_cout0", out_cout, 0);
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    check("chain_q1", out_q, 32'h0000_0001);
    check("chain_last1", out_last, 1);
    check("chain_cout1", out_cout, 0);
    @(posedge clk); #1;
    check("idle_valid_clear", out_valid, 0);

    // Four-word op with a 3-cycle stall on the output
    send(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
    check("bp_q0", out_q, 32'h0000_0001);
    send(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    check("bp_q1", out_q, 32'h1234_567A);
    out_ready = 1'b0;
    in_a = 32'h8000_0000; in_b = 32'h8000_0000; in_cin = 1'b0;
    in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_q", out_q, 32'h1234_567A);
      check("bp_hold_valid", out_valid, 1);
      $display("stall cycle %0d q=%08h in_ready=%0d", i, out_q, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_q2", out_q, 32'h0000_0000);
    check("bp_last2", out_last, 0);
    send(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    check("bp_q3", out_q, 32'h0000_0000);
    check("bp_last3", out_last, 1);
    check("bp_cout3", out_cout, 1);

    // in_first on word 2 of 3 restarts with in_cin and pulses err once
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    check("frm_q0", out_q, 32'h0000_0000);
    check("frm_err0", err, 0);
    send(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1, 1'b0);
    check("frm_q1", out_q, 32'h0000_000B);
    check("frm_err1", err, 1);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    check("frm_q2", out_q, 32'hFFFF_FFFF);
    check("frm_cout2", out_cout, 0);
    check("frm_err2", err, 0);

    // Reset after word 1 of 2, then a word without in_first
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_q", out_q, 0);
    check("mrst_in_ready", in_ready, 1);
    send(32'h0000_0002, 32'h0000_0003, 1'b1, 1'b0, 1'b1);
    check("mrst_err", err, 1);
    check("mrst_q1", out_q, 32'h0000_0006);
    check("mrst_cout", out_cout, 0);
    check("mrst_last", out_last, 1);
    @(posedge clk); #1;
    check("mrst_err_clear", err, 0);

`ifdef MPADD_SEQ_ZERO_FLAG_EN
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    check("zf_word0", out_zero, 0);
    send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    check("zf_last", out_zero, 1);
    send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    check("zf_carry", out_zero, 0);
    check("zf_carry_cout", out_cout, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
